// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_unit
// Brief    : Instruction fetch front end: pipelined IMEM requests with
//            in-order responses, feeding a {pc, instr} queue to IF/ID.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter int              MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    output logic                   imem_req,
    output logic [XLEN-1:0]        imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [31:0]            imem_rdata,
    output logic                   out_valid,
    output logic [31:0]            out_instr,
    output logic [XLEN-1:0]        out_pc,
    input  logic                   out_ready,
    input  logic                   redirect,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   resp_err
);
    localparam int c_QW = $clog2(DEPTH);
    localparam int c_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int c_OW = $clog2(MAX_OUT) + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [c_OW-1:0] r_outstanding;
    logic [c_OW-1:0] r_discard;
    logic [c_QW:0]   r_count;
    logic [c_QW-1:0] r_q_rd;
    logic [c_QW-1:0] r_q_wr;
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [31:0]     r_q_instr [DEPTH];
    logic [XLEN-1:0] r_pend    [MAX_OUT];
    logic [c_PW-1:0] r_pend_rd;
    logic [c_PW-1:0] r_pend_wr;
    logic            r_resp_err;

    logic            w_issue;
    logic            w_drop;
    logic            w_accept;
    logic            w_resp;
    logic            w_spurious;
    logic            w_push;
    logic            w_pop;
    logic [c_QW+1:0] w_reserved;

    function automatic logic [c_PW-1:0] pend_next(input logic [c_PW-1:0] p);
        return (p == c_PW'(MAX_OUT - 1)) ? '0 : p + c_PW'(1);
    endfunction

    // Queue slots are reserved at issue time, so a response always has room.
    assign w_reserved = (c_QW+2)'(r_count) + (c_QW+2)'(r_outstanding);
    assign imem_req   = reset & fetch_en & ~redirect
                      & (r_outstanding < c_OW'(MAX_OUT))
                      & (w_reserved < (c_QW+2)'(DEPTH));
    assign imem_addr  = r_fetch_pc;

    assign w_issue    = imem_req & imem_gnt;
    assign w_drop     = imem_rvalid & (r_discard != '0);
    assign w_accept   = imem_rvalid & (r_discard == '0) & (r_outstanding != '0);
    assign w_resp     = w_drop | w_accept;
    assign w_spurious = imem_rvalid & (r_outstanding == '0);
    assign w_push     = w_accept & ~redirect;
    assign w_pop      = out_valid & out_ready & ~redirect;

    assign out_valid  = (r_count != '0);
    assign out_pc     = r_q_pc[r_q_rd];
    assign out_instr  = r_q_instr[r_q_rd];
    assign occupancy  = r_count;
    assign resp_err   = r_resp_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_q_rd        <= '0;
            r_q_wr        <= '0;
            r_pend_rd     <= '0;
            r_pend_wr     <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_spurious) begin
                r_resp_err <= 1'b1;
            end
            r_outstanding <= r_outstanding + c_OW'(w_issue) - c_OW'(w_resp);
            if (redirect) begin
                // Everything still in flight after this cycle's response is stale.
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_discard  <= r_outstanding - c_OW'(w_resp);
                r_count    <= '0;
                r_q_rd     <= '0;
                r_q_wr     <= '0;
                r_pend_rd  <= '0;
                r_pend_wr  <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                    r_pend_wr  <= pend_next(r_pend_wr);
                end
                if (w_drop) begin
                    r_discard <= r_discard - c_OW'(1);
                end
                if (w_accept) begin
                    r_pend_rd <= pend_next(r_pend_rd);
                end
                if (w_push) begin
                    r_q_wr <= r_q_wr + c_QW'(1);
                end
                if (w_pop) begin
                    r_q_rd <= r_q_rd + c_QW'(1);
                end
                r_count <= r_count + (c_QW+1)'(w_push) - (c_QW+1)'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pend[r_pend_wr] <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_pc[r_q_wr]    <= r_pend[r_pend_rd];
            r_q_instr[r_q_wr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_unit
// Brief    : Directed self-checking bench for fetch_queue_unit with a small
//            in-order IMEM responder of configurable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_unit;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    logic        resp_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int lat   = 1;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_en   (fetch_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_ready  (out_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .occupancy  (occupancy),
        .resp_err   (resp_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ {16'h0000, a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record a grant, cross the edge, then present this cycle's response.
    task automatic step();
        #1;
        if (imem_req && imem_gnt) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        chk("inv_occ_plus_outstanding",
            32'((occupancy + mq_due.size() + imem_rvalid) <= DEPTH), 32'd1);
        #1;
    endtask

    initial begin
        reset = 1'b0; fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step();
        fetch_en = 1'b1;
        #1;
        chk("req_during_reset", imem_req, 0);
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming, 1-cycle latency
        reset = 1'b1; imem_gnt = 1'b1; out_ready = 1'b1; lat = 1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_req", imem_req, 1);
            chk("stream_addr", imem_addr, 32'(4 * i));
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_pc", out_pc, 32'(4 * (i - 2)));
                chk("stream_instr", out_instr, mem_word(32'(4 * (i - 2))));
                chk("stream_occ", occupancy, 1);
            end else begin
                chk("stream_fill_valid", out_valid, 0);
            end
            step();
        end

        // Back-pressure until full
        out_ready = 1'b0;
        repeat (20) step();
        chk("bp_occ", occupancy, 4);
        chk("bp_req", imem_req, 0);
        chk("bp_outstanding", mq_due.size(), 0);
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk("bp_drain_valid", out_valid, 1);
            chk("bp_drain_pc", out_pc, 32'(24 + 4 * j));
            chk("bp_drain_instr", out_instr, mem_word(32'(24 + 4 * j)));
            step();
        end
        fetch_en = 1'b0;
        repeat (8) step();
        chk("drain_occ", occupancy, 0);
        chk("drain_outstanding", mq_due.size(), 0);

        // Redirect with two requests in flight, 3-cycle latency
        lat = 3; fetch_en = 1'b1;
        step();
        step();
        chk("redir_outstanding", mq_due.size(), 2);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        chk("redir_req_low", imem_req, 0);
        step();
        redirect = 1'b0;
        #1;
        chk("redir_r3_req", imem_req, 0);
        chk("redir_r3_occ", occupancy, 0);
        step();
        chk("redir_first_req", imem_req, 1);
        chk("redir_first_addr", imem_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("redir_no_stale", out_valid, 0);
        end
        step();
        chk("redir_head_valid", out_valid, 1);
        chk("redir_head_pc", out_pc, 32'h100);
        chk("redir_head_instr", out_instr, mem_word(32'h100));
        step();
        chk("redir_next_pc", out_pc, 32'h104);
        out_ready = 1'b0;
        step();
        step();
        chk("combo_head_pc", out_pc, 32'h104);

        // Redirect with a same-cycle response and pop attempt
        redirect = 1'b1; redirect_pc = 32'h0000_0200; out_ready = 1'b1;
        step();
        redirect = 1'b0;
        #1;
        chk("combo_valid", out_valid, 0);
        chk("combo_occ", occupancy, 0);
        chk("combo_req", imem_req, 1);
        chk("combo_addr", imem_addr, 32'h200);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("combo_no_stale", out_valid, 0);
        end
        step();
        chk("combo_first_valid", out_valid, 1);
        chk("combo_first_pc", out_pc, 32'h200);

        // Grant stalls across the address wrap
        fetch_en = 1'b0;
        repeat (8) step();
        chk("wrap_pre_occ", occupancy, 0);
        chk("wrap_pre_outstanding", mq_due.size(), 0);
        imem_gnt = 1'b0; lat = 1; fetch_en = 1'b1;
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0; imem_gnt = 1'b1;
        #1;
        chk("wrap_w0_req", imem_req, 1);
        chk("wrap_w0_addr", imem_addr, 32'hFFFF_FFF8);
        step();
        imem_gnt = 1'b0;
        #1;
        chk("wrap_w1_req", imem_req, 1);
        chk("wrap_w1_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_w2_addr_held", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_w2_pc", out_pc, 32'hFFFF_FFF8);
        chk("wrap_w2_valid", out_valid, 1);
        imem_gnt = 1'b1;
        step();
        chk("wrap_w3_addr", imem_addr, 32'h0000_0000);
        chk("wrap_w3_valid", out_valid, 0);
        step();
        fetch_en = 1'b0;
        chk("wrap_w4_valid", out_valid, 1);
        chk("wrap_w4_pc", out_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_w5_pc", out_pc, 32'h0000_0000);
        chk("wrap_w5_instr", out_instr, mem_word(32'h0000_0000));
        out_ready = 1'b0;
        step();
        chk("wrap_w6_occ", occupancy, 1);

        // Spurious response, then mid-run reset
        chk("spur_pre_err", resp_err, 0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        chk("spur_err", resp_err, 1);
        chk("spur_occ", occupancy, 1);
        chk("spur_pc", out_pc, 32'h0000_0000);
        step();
        chk("spur_sticky", resp_err, 1);
        reset = 1'b0; fetch_en = 1'b1;
        #1;
        chk("mid_reset_req", imem_req, 0);
        step();
        reset = 1'b1;
        #1;
        chk("mid_reset_valid", out_valid, 0);
        chk("mid_reset_occ", occupancy, 0);
        chk("mid_reset_err", resp_err, 0);
        chk("mid_reset_addr", imem_addr, 32'h0000_0000);
        chk("mid_reset_req_after", imem_req, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
